// File: rtl/insert_y_pkg.sv
// Shared constants for the marker-digit insert/remove pair: word geometry,
// marker values, reserved position bounds and the builder FSM states.
package insert_y_pkg;

    localparam int N        = 98;
    localparam int RESERVED = 13;
    localparam int M        = N - RESERVED;
    localparam int K_W      = 7;

    localparam logic [1:0] Y_LO = 2'b11;
    localparam logic [1:0] Y_A  = 2'b10;
    localparam logic [1:0] Y_B  = 2'b01;
    localparam logic [1:0] Y_HI = 2'b11;

    // Reserved digit ranges; the removal stage strips exactly these positions.
    localparam int LO_FIRST = 0;
    localparam int LO_LAST  = 4;
    localparam int A_FIRST  = 14;
    localparam int A_LAST   = 16;
    localparam int B_FIRST  = 62;
    localparam int B_LAST   = 64;
    localparam int HI_FIRST = 96;
    localparam int HI_LAST  = 97;

    typedef enum logic [1:0] {IDLE, BUILD, HOLD} state_t;

    function automatic logic in_range(input logic [K_W-1:0] k, input int first, input int last);
        return (int'(k) >= first) && (int'(k) <= last);
    endfunction

endpackage

// File: rtl/insert_y_posdec.sv
// Decodes a channel digit index into "reserved" plus the marker value to
// write there.
module insert_y_posdec
    import insert_y_pkg::*;
(
    input  logic [K_W-1:0] k,
    output logic           reserved,
    output logic [1:0]     marker
);

    always_comb begin
        // NOTE: every output gets a default before the branches so no path leaves it unassigned (no latch).
        reserved = 1'b1;
        marker   = 2'b00;
        if (in_range(k, LO_FIRST, LO_LAST)) begin
            marker = Y_LO;
        end else if (in_range(k, A_FIRST, A_LAST)) begin
            marker = Y_A;
        end else if (in_range(k, B_FIRST, B_LAST)) begin
            marker = Y_B;
        end else if (in_range(k, HI_FIRST, HI_LAST)) begin
            marker = Y_HI;
        end else begin
            reserved = 1'b0;
        end
    end

endmodule

// File: rtl/insert_y.sv
// Builds the N-digit channel word one digit per cycle from an M-digit payload,
// inserting fixed markers at the reserved positions, then holds it for the consumer.
module insert_y
    import insert_y_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*M-1:0]   word_in,
    input  logic [K_W-1:0]   word_in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   word_out,
    output logic [K_W-1:0]   word_out_len,
    output logic             len_err
);

    state_t           state, state_next;
    logic [K_W-1:0]   k;
    logic [K_W-1:0]   consumed;
    logic [2*M-1:0]   payload;
    logic [2*N-1:0]   word;
    logic             len_err_q;
    logic             k_reserved;
    logic [1:0]       k_marker;
    logic             last_digit;

    assign last_digit = (k == K_W'(N - 1));

    insert_y_posdec u_posdec (
        .k        (k),
        .reserved (k_reserved),
        .marker   (k_marker)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = BUILD;
            BUILD:   if (last_digit) state_next = HOLD;
            HOLD:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // NOTE: the payload and word registers are reset too, so a build cut short by reset leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k         <= '0;
            consumed  <= '0;
            payload   <= '0;
            word      <= '0;
            len_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        payload   <= word_in;
                        k         <= '0;
                        consumed  <= '0;
                        word      <= '0;
                        len_err_q <= (word_in_len != K_W'(M));
                    end
                end
                BUILD: begin
                    word[{k, 1'b0} +: 2] <= k_reserved ? k_marker : payload[1:0];
                    if (!k_reserved) begin
                        payload  <= payload >> 2;
                        consumed <= consumed + K_W'(1);
                    end
                    k <= k + K_W'(1);
                end
                default: ;
            endcase
        end
    end

    // in_ready is forced low while reset is asserted so every output reads 0 then.
    assign in_ready     = rst && (state == IDLE);
    assign out_valid    = (state == HOLD);
    assign word_out_len = out_valid ? K_W'(N) : '0;
    assign word_out     = word;
    assign len_err      = len_err_q;

    a_consumed_m: assert property (@(posedge clk) disable iff (!rst)
        (state == BUILD && last_digit) |-> (consumed == K_W'(M)));

endmodule

// File: tb/tb_insert_y.sv
// Randomized scoreboard bench for insert_y: accepted payloads are modelled as a
// segment-by-segment digit stream and compared when the DUT hands the word over.
module tb_insert_y;

    localparam int N = 98;
    localparam int M = 85;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*M-1:0] word_in = '0;
    logic [6:0]     word_in_len = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] word_out;
    logic [6:0]     word_out_len;
    logic           len_err;

    typedef struct {
        logic [2*N-1:0] word;
        logic           len_err;
    } exp_t;

    exp_t           exp_q[$];
    int             acc_q[$];
    int             acc_hist[$];
    int             xfer_hist[$];
    int             cyc = 0;
    int             n_cmp = 0;
    int             n_fail = 0;
    logic           ov_prev = 1'b0;
    logic [2*N-1:0] held_word = '0;
    logic [2*N-1:0] last_word = '0;
    logic           last_len_err = 1'b0;
    exp_t           mon_e;
    bit             rnd_bp = 1'b0;

    insert_y dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .word_in      (word_in),
        .word_in_len  (word_in_len),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .word_out     (word_out),
        .word_out_len (word_out_len),
        .len_err      (len_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Channel word = marker run, payload run, marker run, ... taken from the digit map.
    function automatic logic [2*N-1:0] build_ref(input logic [2*M-1:0] p);
        int         seg_len[7]  = '{5, 9, 3, 45, 3, 31, 2};
        logic [1:0] seg_mark[7] = '{2'b11, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b11};
        logic [1:0] d[$];
        logic [2*N-1:0] w = '0;
        int j = 0;
        for (int s = 0; s < 7; s++) begin
            for (int n = 0; n < seg_len[s]; n++) begin
                if (s % 2 == 0) begin
                    d.push_back(seg_mark[s]);
                end else begin
                    d.push_back(p[2*j +: 2]);
                    j++;
                end
            end
        end
        for (int k = 0; k < N; k++) w[2*k +: 2] = d[k];
        return w;
    endfunction

    // What the removal stage does: drop the 13 reserved digits.
    function automatic logic [2*M-1:0] strip(input logic [2*N-1:0] w);
        logic [2*M-1:0] p = '0;
        int j = 0;
        for (int k = 0; k < N; k++) begin
            if (!(k <= 4 || (k >= 14 && k <= 16) || (k >= 62 && k <= 64) || k >= 96)) begin
                p[2*j +: 2] = w[2*k +: 2];
                j++;
            end
        end
        return p;
    endfunction

    function automatic logic [2*M-1:0] rand_payload();
        logic [2*M-1:0] p;
        for (int j = 0; j < M; j++) p[2*j +: 2] = 2'($urandom_range(0, 3));
        return p;
    endfunction

    // Input and output monitor: scoreboard push on accept, pop on handover.
    always @(negedge clk) begin
        if (!rst) begin
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                mon_e.word    = build_ref(word_in);
                mon_e.len_err = (word_in_len != 7'(M));
                exp_q.push_back(mon_e);
                acc_q.push_back(cyc + 1);
                acc_hist.push_back(cyc + 1);
            end
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) check("latency_no_accept", 0, 1);
                else check("latency", cyc - acc_q.pop_front(), N);
                check("out_len", word_out_len, N);
                held_word = word_out;
            end
            if (out_valid && ov_prev) begin
                check("hold_stable", word_out, held_word);
                check("hold_in_ready", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_out", word_out, mon_e.word);
                    check("len_err", len_err, mon_e.len_err);
                end
                last_word    = word_out;
                last_len_err = len_err;
                xfer_hist.push_back(cyc + 1);
            end
            ov_prev = out_valid;
        end
    end

    task automatic send(input logic [2*M-1:0] p, input logic [6:0] len, input bit keep);
        int waited = 0;
        word_in     = p;
        word_in_len = len;
        in_valid    = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_word_out"},  word_out, 0);
        check({tag, "_out_len"},   word_out_len, 0);
        check({tag, "_len_err"},   len_err, 0);
    endtask

    initial begin
        logic [2*M-1:0] p;
        int waited;
        int i0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // All-zero payload: only the markers are non-zero.
        send('0, 7'(85), 1'b0);
        drain();
        check("zeros_len_err", last_len_err, 0);
        check("zeros_d0",  last_word[1:0],     2'b11);
        check("zeros_d15", last_word[31:30],   2'b10);
        check("zeros_d63", last_word[127:126], 2'b01);
        check("zeros_d97", last_word[195:194], 2'b11);
        check("zeros_d50", last_word[101:100], 2'b00);

        // Payload digit j = j mod 4.
        for (int j = 0; j < M; j++) p[2*j +: 2] = 2'(j % 4);
        send(p, 7'(85), 1'b0);
        drain();
        check("mod4_d5",  last_word[11:10],   p[1:0]);
        check("mod4_d13", last_word[27:26],   p[17:16]);
        check("mod4_d17", last_word[35:34],   p[19:18]);
        check("mod4_d95", last_word[191:190], p[169:168]);
        check("mod4_strip", strip(last_word), p);

        // Short declared length flags len_err; the next good length clears it.
        send(rand_payload(), 7'(84), 1'b0);
        drain();
        check("len84_err", last_len_err, 1);
        send(rand_payload(), 7'(85), 1'b0);
        drain();
        check("len85_err", last_len_err, 0);

        // Back-pressure: hold 20 cycles with the next word already offered.
        out_ready = 1'b0;
        send(rand_payload(), 7'(85), 1'b0);
        waited = 0;
        while (!out_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("bp_out_valid", out_valid, 1);
        repeat (20) @(negedge clk);
        fork
            send(rand_payload(), 7'(85), 1'b0);
        join_none
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_accept_gap", acc_hist[acc_hist.size()-1] - xfer_hist[xfer_hist.size()-1], 1);
        drain();

        // Back-to-back with in_valid held high.
        i0 = acc_hist.size();
        send(rand_payload(), 7'(85), 1'b1);
        send(rand_payload(), 7'(85), 1'b0);
        drain();
        if (acc_hist.size() < i0 + 2) check("b2b_accepts", acc_hist.size(), i0 + 2);
        else check("b2b_spacing", acc_hist[i0+1] - acc_hist[i0], N + 2);

        // Reset in the middle of a build discards the partial word.
        send(rand_payload(), 7'(85), 1'b0);
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        p = rand_payload();
        send(p, 7'(85), 1'b0);
        drain();
        check("midrst_strip", strip(last_word), p);

        // Random words, random lengths, random back-pressure.
        rnd_bp = 1'b1;
        for (int w = 0; w < 6; w++) begin
            send(rand_payload(), ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : 7'(85), 1'b0);
        end
        drain();
        rnd_bp = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/insert_y.md
# insert_y

Transmit-side counterpart of the marker-digit removal stage. Accepts an M-digit payload word (2 bits per digit) over a valid/ready handshake, then builds the N-digit channel word one digit per cycle: fixed marker digits at four reserved position groups, payload digits in order everywhere else. The finished word is held on a valid/ready output until taken. It sits between the payload encoder and the differential-word stage.

## Interface
- N, 98, digits in the output word
- M, N-13, digits in the payload word; must equal N minus the 13 reserved positions
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  payload word valid
- in_ready  out  1  block can accept a payload word
- word_in  in  2*M  payload; digit j = bits [2j+1:2j]
- word_in_len  in  7  declared payload length in digits
- out_valid  out  1  word_out complete and stable
- out_ready  in  1  consumer takes word_out
- word_out  out  2*N  channel word; digit k = bits [2k+1:2k]
- word_out_len  out  7  N while out_valid, else 0
- len_err  out  1  captured word_in_len differed from M

## Operation
- Reserved digit indices: 0–4, 14–16, 62–64, 96–97 (13 total).
- Marker values are package constants: Y_LO (indices 0–4) = 2'b11, Y_A (14–16) = 2'b10, Y_B (62–64) = 2'b01, Y_HI (96–97) = 2'b11.
- FSM states: IDLE, BUILD, HOLD.
- IDLE: in_ready=1. On in_valid&in_ready, capture word_in into the payload shift register, set index k=0, clear the word register, set len_err = (word_in_len != M), go to BUILD.
- BUILD: in_ready=0. Each cycle, write digit k:
  - k reserved: write its marker constant.
  - k not reserved: write payload digit 0, then shift the payload right by 2.
  - Then k=k+1. At k=N-1, after writing, go to HOLD.
- HOLD: out_valid=1, word_out stable, word_out_len=N. On out_ready, go to IDLE and clear out_valid.
- Payload digits consumed in BUILD: exactly M. A consumption counter ≠ M at the end of BUILD is a design error. It is flagged by a simulation assertion, not a port.
- len_err is informational only. It does not change the built word, and it holds until the next accept.
- Reset (any state, including mid-BUILD): state=IDLE, k=0, payload and word registers cleared, in_ready=1 after release, out_valid=0, word_out=0, word_out_len=0, len_err=0. A partial word is discarded.
- in_valid during BUILD or HOLD is ignored. The upstream must hold it until in_ready.

## Timing
- Accept on edge T. Digit k is written on edge T+1+k. out_valid rises after edge T+N (98 edges after accept).
- HOLD lasts at least 1 cycle. HOLD→IDLE occurs on the edge where out_valid&out_ready. in_ready rises in the same cycle as that edge takes effect.
- Minimum word period: N+2 cycles (98 build + 1 HOLD + 1 IDLE accept).
- With out_ready held low, HOLD persists indefinitely and word_out does not change.
- word_out changes only in BUILD.
- All outputs are registered or decoded from state only. There are no combinational paths from in_valid or out_ready to any output.

## Structure
- Package insert_y_pkg holds:
  - Y_LO, Y_A, Y_B, Y_HI
  - the reserved-range bounds (0/4, 14/16, 62/64, 96/97)
  - the state enum {IDLE, BUILD, HOLD}
  - Bounds are shared with the removal stage so both ends agree.
- One sub-module: insert_y_posdec, a combinational decode of k into reserved flag plus marker value.
- FSM, counter and shift register live in the top.

## Test plan
- Payload all 2'b00 (M=85), word_in_len=85, out_ready=1:
  - word_out digits 0–4 = 3, 14–16 = 2, 62–64 = 1, 96–97 = 3, all other digits 0
  - out_valid 98 edges after accept; len_err=0.
- Payload digit j = j mod 4:
  - word_out digit 5 = payload 0, digit 13 = payload 8, digit 17 = payload 9, digit 95 = payload 84.
  - Feeding word_out through the removal stage returns word_in exactly.
- out_ready low for 20 cycles after out_valid:
  - word_out and out_valid stable, in_ready=0 throughout.
  - Accept occurs one cycle after out_ready rises.
- Back-to-back words with in_valid held high: second accept exactly N+2 cycles after the first.
- word_in_len=84 → len_err=1 with correct word_out; next word with len 85 → len_err=0.
- rst low at k=40, then released, then a new payload: word_out reflects only the new payload; all outputs 0 during reset.
